// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the USB receive byte sequencer.
package rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC      = 3'd1,
    RECEIVE   = 3'd2,
    BYTE_DONE = 3'd3,
    EOP_WAIT  = 3'd4,
    ERROR     = 3'd5
  } rx_state_t;

  localparam int         BITS_PER_BYTE = 8;
  localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

  // Count value present while the last bit of a byte is being shifted.
  localparam logic [3:0] LAST_BIT_CNT  = 4'(BITS_PER_BYTE - 1);

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// 4-bit shift counter with synchronous clear; rollover flags a full byte.
module rx_bit_counter
  import rx_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] count,
  output logic       rollover
);

  // Clear has priority over counting so a state change always restarts at 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  assign rollover = (count == 4'(BITS_PER_BYTE));

endmodule

// File: rtl/rx_byte_ctrl.sv
// Receive-side sequencer for the 8-bit USB shift register: gates shifting,
// checks SYNC, hands completed bytes downstream and flags framing errors.
// Optional feature macro: RX_BYTE_CTRL_ERR_CNT_EN adds a saturating err_count.
//
// Downstream handshake: byte_ready is a one-cycle valid pulse with no ready
// back-pressure; rx_byte is valid in that cycle and holds until the next pulse.
module rx_byte_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = USB_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_det,
  input  logic       bit_strobe,
  input  logic       eop,
  input  logic [7:0] rcv_data,
  output logic       shift_enable,
  output logic       byte_ready,
  output logic [7:0] rx_byte,
  output logic       packet_done,
  output logic       rx_error,
  output rx_state_t  state_dbg
`ifdef RX_BYTE_CTRL_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  rx_state_t  state_q;
  rx_state_t  next_state;
  logic [3:0] bit_count;
  logic       rollover;
  logic       cnt_clear;
  logic       entering_error;
  logic       eop_seen;
  logic [7:0] rx_byte_q;

  // eop beats a simultaneous strobe, so no bit is shifted on the EOP cycle.
  assign shift_enable = bit_strobe & ((state_q == SYNC) | (state_q == RECEIVE)) & ~eop;

  // Every state change restarts the bit count; IDLE keeps it parked at 0.
  assign cnt_clear      = (state_q != next_state) | (state_q == IDLE);
  assign entering_error = (next_state == ERROR) & (state_q != ERROR);
  assign state_dbg      = state_q;

  // rcv_data only becomes valid in BYTE_DONE, so rx_byte is forwarded from it
  // in that cycle and held from the capture register afterwards.
  assign rx_byte = (state_q == BYTE_DONE) ? rcv_data : rx_byte_q;

  rx_bit_counter u_bit_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (cnt_clear),
    .enable   (shift_enable),
    .count    (bit_count),
    .rollover (rollover)
  );

  // Next-state decode.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_det) next_state = SYNC;
      end
      SYNC: begin
        // rollover marks the cycle after the 8th shift, when rcv_data is valid.
        if (eop)           next_state = ERROR;
        else if (rollover) next_state = (rcv_data == SYNC_BYTE) ? RECEIVE : ERROR;
      end
      RECEIVE: begin
        if (eop)                                         next_state = (bit_count == 4'd0) ? EOP_WAIT : ERROR;
        else if (shift_enable && bit_count == LAST_BIT_CNT) next_state = BYTE_DONE;
      end
      BYTE_DONE: next_state = RECEIVE;
      EOP_WAIT: begin
        if (!eop) next_state = IDLE;
      end
      ERROR: begin
        if (eop_seen && !eop) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      byte_ready  <= 1'b0;
      packet_done <= 1'b0;
      rx_error    <= 1'b0;
      eop_seen    <= 1'b0;
      rx_byte_q   <= 8'h00;
    end else begin
      state_q     <= next_state;
      byte_ready  <= (next_state == BYTE_DONE);
      packet_done <= (state_q == EOP_WAIT) && (next_state == IDLE);
      if (state_q == IDLE && start_det) begin
        rx_error <= 1'b0;
      end else if (entering_error) begin
        rx_error <= 1'b1;
      end
      // An eop already present on entry counts as seen.
      if (entering_error) begin
        eop_seen <= eop;
      end else if (state_q == ERROR && eop) begin
        eop_seen <= 1'b1;
      end
      if (state_q == BYTE_DONE) begin
        rx_byte_q <= rcv_data;
      end
    end
  end

`ifdef RX_BYTE_CTRL_ERR_CNT_EN
  // Error entry counter, saturating, cleared only by reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_count <= 8'h00;
    end else if (entering_error) begin
      err_count <= sat_inc8(err_count);
    end
  end
`endif

endmodule

// File: tb/tb_rx_byte_ctrl.sv
// Bench for rx_byte_ctrl: table of packet vectors, directed reset/timing
// sequences and randomized packets against a packet-level reference model.
module tb_rx_byte_ctrl;
  import rx_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start_det = 1'b0;
  logic       bit_strobe = 1'b0;
  logic       eop = 1'b0;
  logic [7:0] rcv_data;
  logic       shift_enable;
  logic       byte_ready;
  logic [7:0] rx_byte;
  logic       packet_done;
  logic       rx_error;
  rx_state_t  state_dbg;
`ifdef RX_BYTE_CTRL_ERR_CNT_EN
  logic [7:0] err_count;
  int         exp_err_cnt = 0;
`endif

  logic       serial_bit = 1'b0;
  logic [7:0] sr = 8'h00;
  logic [7:0] got_q[$];
  int         done_cnt = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         noise = 1'b0;

  typedef struct {
    logic [7:0]  sync;
    int          n_bytes;
    logic [31:0] data;
    int          tail_bits;
    bit          eop_strobe;
    int          exp_ready;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  rx_byte_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start_det    (start_det),
    .bit_strobe   (bit_strobe),
    .eop          (eop),
    .rcv_data     (rcv_data),
    .shift_enable (shift_enable),
    .byte_ready   (byte_ready),
    .rx_byte      (rx_byte),
    .packet_done  (packet_done),
    .rx_error     (rx_error),
    .state_dbg    (state_dbg)
`ifdef RX_BYTE_CTRL_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stand-in for the shift register: LSB-first, new bit enters at the MSB.
  always @(posedge clk) if (shift_enable) sr <= {serial_bit, sr[7:1]};
  assign rcv_data = sr;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (n_rst) begin
      if (byte_ready)  got_q.push_back(rx_byte);
      if (packet_done) done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe cycle followed by one idle cycle (minimum legal spacing).
  task automatic send_bit(input logic b);
    serial_bit = b;
    bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
    start_det  = noise && ($urandom_range(0, 7) == 0);
    tick();
    start_det  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  // Packet-level reference: what a correct receiver reports for this packet.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit good = (v.sync == 8'h80);
    r.exp_ready = good ? v.n_bytes : 0;
    r.exp_done  = good && (v.tail_bits == 0);
    r.exp_err   = !good || (v.tail_bits != 0);
    return r;
  endfunction

  task automatic run_pkt(input string tag, input vec_t v);
    logic [7:0] b;
    got_q.delete();
    done_cnt  = 0;
    start_det = 1'b1;
    tick();
    start_det = 1'b0;
    chk({tag, " err_clear_on_start"}, 32'(rx_error), 32'd0);
    send_byte(v.sync);
    for (int i = 0; i < v.n_bytes; i++) begin
      b = v.data[8*i +: 8];
      send_byte(b);
    end
    for (int i = 0; i < v.tail_bits; i++) send_bit(1'($urandom_range(0, 1)));
    eop        = 1'b1;
    bit_strobe = v.eop_strobe;
    @(negedge clk);
    if (v.eop_strobe) chk({tag, " shift_en_eop_wins"}, 32'(shift_enable), 32'd0);
    tick();
    bit_strobe = 1'b0;
    tick();
    eop = 1'b0;
    repeat (4) tick();
    chk({tag, " ready_count"}, 32'(got_q.size()), 32'(v.exp_ready));
    for (int i = 0; i < v.exp_ready && i < got_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(v.data[8*i +: 8]));
    chk({tag, " packet_done"}, 32'(done_cnt), 32'(v.exp_done));
    chk({tag, " rx_error"}, 32'(rx_error), 32'(v.exp_err));
    chk({tag, " back_to_idle"}, 32'(state_dbg), 32'(IDLE));
`ifdef RX_BYTE_CTRL_ERR_CNT_EN
    if (v.exp_err && exp_err_cnt < 255) exp_err_cnt++;
    chk({tag, " err_count"}, 32'(err_count), 32'(exp_err_cnt));
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " shift_enable"}, 32'(shift_enable), 32'd0);
    chk({tag, " byte_ready"},   32'(byte_ready),   32'd0);
    chk({tag, " rx_byte"},      32'(rx_byte),      32'd0);
    chk({tag, " packet_done"},  32'(packet_done),  32'd0);
    chk({tag, " rx_error"},     32'(rx_error),     32'd0);
    chk({tag, " state"},        32'(state_dbg),    32'(IDLE));
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    logic [7:0] a5 = 8'hA5;

    // fields: sync, n_bytes, data, tail_bits, eop_strobe, exp_ready, exp_done, exp_err
    tbl[0] = '{8'h80, 2, 32'h0000_3CA5, 0, 1'b0, 2, 1'b1, 1'b0};  // clean packet
    tbl[1] = '{8'h81, 2, 32'h0000_2211, 0, 1'b0, 0, 1'b0, 1'b1};  // bad sync
    tbl[2] = '{8'h80, 0, 32'h0000_0000, 3, 1'b0, 0, 1'b0, 1'b1};  // eop after 3 bits
    tbl[3] = '{8'h80, 1, 32'h0000_005A, 0, 1'b1, 1, 1'b1, 1'b0};  // eop with strobe
    tbl[4] = '{8'h80, 0, 32'h0000_0000, 0, 1'b0, 0, 1'b1, 1'b0};  // empty packet
    tbl[5] = '{8'h80, 2, 32'h0000_00FF, 7, 1'b0, 2, 1'b0, 1'b1};  // eop after 7 bits

    // reset
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("reset");
    n_rst = 1'b1;
    tick();

    // table vectors
    foreach (tbl[i]) run_pkt($sformatf("vec%0d", i), tbl[i]);

    // byte_ready timing, then async reset 5 bits into the next byte
    start_det = 1'b1;
    tick();
    start_det = 1'b0;
    send_byte(8'h80);
    for (int i = 0; i < 7; i++) send_bit(a5[i]);
    serial_bit = a5[7];
    bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
    chk("timing ready_rise", 32'(byte_ready), 32'd1);
    chk("timing rx_byte",    32'(rx_byte),    32'hA5);
    tick();
    chk("timing ready_fall", 32'(byte_ready), 32'd0);
    chk("timing rx_byte_hold", 32'(rx_byte),  32'hA5);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bit_strobe = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    bit_strobe = 1'b0;
    tick();
    n_rst = 1'b1;
`ifdef RX_BYTE_CTRL_ERR_CNT_EN
    exp_err_cnt = 0;
`endif
    tick();
    run_pkt("after_rst", '{8'h80, 2, 32'h0000_C3E7, 0, 1'b0, 2, 1'b1, 1'b0});

`ifdef RX_BYTE_CTRL_ERR_CNT_EN
    // error counter: three bad syncs, then a clean packet
    for (int i = 0; i < 3; i++) run_pkt($sformatf("errcnt_bad%0d", i), tbl[1]);
    run_pkt("errcnt_clean", tbl[0]);
    chk("err_count_after_3", 32'(err_count), 32'd3);
`endif

    // randomized packets against the reference model
    noise = 1'b1;
    for (int k = 0; k < 40; k++) begin
      v.sync       = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h80;
      v.n_bytes    = $urandom_range(0, 4);
      v.data       = $urandom;
      v.tail_bits  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      v.eop_strobe = 1'($urandom_range(0, 1));
      v            = model(v);
      run_pkt($sformatf("rand%0d", k), v);
    end
    noise = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_byte_ctrl.md
# rx_byte_ctrl

Receive-side sequencer for the 8-bit serial-to-parallel shift register (`shift_register_2`) in the USB receiver path. It gates `shift_enable` from the bit-timing strobe and counts bits. It checks the leading SYNC byte, then latches each completed data byte and pulses `byte_ready` to the downstream FIFO writer. It also flags framing errors when EOP arrives mid-byte or SYNC mismatches.

## Interface
- `SYNC_BYTE`, default 8'h80, value `rcv_data` must equal after the first 8 shifted bits.
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous active-low reset.
- `start_det`  in  1  one-cycle pulse, packet start detected on the line.
- `bit_strobe`  in  1  one-cycle pulse per sampled bit.
- `eop`  in  1  level, end-of-packet condition present.
- `rcv_data`  in  8  parallel output of the shift register.
- `shift_enable`  out  1  drives the shift register's `shift_enable`.
- `byte_ready`  out  1  one-cycle pulse, `rx_byte` holds a new data byte.
- `rx_byte`  out  8  last completed data byte.
- `packet_done`  out  1  one-cycle pulse on clean end of packet.
- `rx_error`  out  1  level, framing or sync error in the current packet.

## Operation
- States: IDLE, SYNC, RECEIVE, BYTE_DONE, EOP_WAIT, ERROR. All state is 2-process Moore, except `shift_enable`.
- `shift_enable = bit_strobe & (state==SYNC | state==RECEIVE) & ~eop`. This is combinational, with zero latency.
- The 4-bit bit counter increments on each gated shift and clears on entry to SYNC, RECEIVE-from-BYTE_DONE, and IDLE.
- IDLE: on `start_det`, go to SYNC and clear `rx_error`.
- SYNC: on the 8th shift, go to SYNC_CHECK behaviour in the same next cycle. If `rcv_data==SYNC_BYTE`, go to RECEIVE; otherwise go to ERROR. `eop` in SYNC goes to ERROR.
- RECEIVE: on the 8th shift, go to BYTE_DONE.
  - `eop` with count==0 goes to EOP_WAIT.
  - `eop` with count!=0 goes to ERROR.
- BYTE_DONE: lasts one cycle. `rx_byte<=rcv_data`, `byte_ready=1`, then return to RECEIVE with count 0. A `bit_strobe` arriving in BYTE_DONE is not shifted.
- EOP_WAIT: wait for `eop` to deassert, then go to IDLE with `packet_done` pulsed for one cycle on that transition.
- ERROR: `rx_error=1`. Wait for `eop` deassert after seeing `eop`, then go to IDLE. `rx_error` holds until the next `start_det`.
- Simultaneous `eop` and `bit_strobe`: `eop` wins and no shift occurs.
- `start_det` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, counter 0, `rx_byte` 8'h00, `byte_ready` 0, `packet_done` 0, `rx_error` 0, `shift_enable` 0.
- The shift register updates at the end of the strobe cycle. `rcv_data` is valid from the next cycle, and that is when the SYNC compare and BYTE_DONE latch occur.
- `byte_ready` rises 1 cycle after the 8th gated strobe. `rx_byte` is stable from the same cycle until the next `byte_ready`.
- Strobe spacing must be ≥2 cycles. The bench enforces this; the RTL does not check it.
- Asynchronous reset mid-packet: all outputs return to reset values immediately. Partial bytes are discarded.

## Configuration
- `RX_BYTE_CTRL_ERR_CNT_EN`:
  - Defined: adds output `err_count` [7:0]. It increments on each entry to ERROR, saturates at 8'hFF, and clears only on `n_rst`.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `rx_ctrl_pkg` holds:
  - the state enum `rx_state_t`;
  - `BITS_PER_BYTE = 8`;
  - the default `USB_SYNC_BYTE = 8'h80`.
- Sub-module `rx_bit_counter` is a 4-bit counter with clear, enable, and a `rollover` flag at 8. It is reused for SYNC and data bytes.

## Test plan
- Clean packet: `start_det`, then 8 strobes shifting to 8'h80, 16 strobes for bytes 8'hA5 and 8'h3C, then `eop`. Required: two `byte_ready` pulses with `rx_byte` 8'hA5 then 8'h3C, then `packet_done` once, `rx_error` 0.
- Bad sync: shifted value 8'h81. Required: ERROR, `rx_error`=1, no `byte_ready`, and return to IDLE after `eop`.
- `eop` after 3 bits of a data byte. Required: `rx_error`=1, no `byte_ready`, no `packet_done`.
- `eop` and `bit_strobe` in the same cycle at count 0 in RECEIVE. Required: `shift_enable` stays 0 and `packet_done` pulses.
- Async reset asserted after 5 data bits. Required: all outputs at reset values the same cycle. A new packet afterwards is received correctly.
- With `RX_BYTE_CTRL_ERR_CNT_EN`: 3 bad-sync packets give `err_count`=3. A clean packet leaves it at 3.
